// File: rtl/lsu_unit_if.sv
// lsu_unit_if: every non-clock signal around lsu_unit, bundled as one interface.
//
// Modports:
//   slave  - the load/store unit itself.
//   master - the environment around the unit: the execute stage that issues
//            accesses and the data memory that serves them.
//
// Execute side : req_valid/req_ready handshake, req_wen, req_funct3, ram_addr,
//                req_wdata in; resp_valid/resp_data/resp_err out (no backpressure).
// Memory side  : mem_req_valid/mem_req_ready handshake carrying mem_addr,
//                mem_wen, mem_wdata, mem_wmask; mem_rsp_valid + mem_rdata return.
interface lsu_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  // execute -> unit
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] req_wdata;
  // unit -> writeback
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  // unit <-> data memory
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_wen, req_funct3, ram_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );

  modport master (
    output req_valid, req_wen, req_funct3, ram_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

// File: rtl/lsu_unit.sv
// lsu_unit: multi-cycle load/store unit sitting after the ALU.
//
// Takes one access at a time from execute, checks size/alignment/encoding,
// issues a single 8-byte-aligned doubleword request to data memory (with the
// store data steered into its byte lanes and a byte-enable mask), and returns
// a sign/zero-extended load value or a store acknowledge as a one-cycle pulse.
// Bad accesses (misaligned, illegal funct3) answer one cycle after accept with
// resp_err=1 and never touch memory.
//
// Ports:
//   clk  - single clock
//   rst  - synchronous, active-high reset
//   bus  - lsu_unit_if.slave: execute request/response and memory port
//
// All outputs come straight from flops except req_ready, which is decoded
// from the state and rst so that it is low while reset is held.
module lsu_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic      clk,
  input  logic      rst,
  lsu_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e            state_q, state_d;
  // Only the byte offset and funct3 are needed after accept: everything else
  // is folded into the mem_* registers at accept time.
  logic [2:0]        off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]        mem_wmask_q, mem_wmask_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;

  logic              req_ready_w;
  logic              accept;

  assign req_ready_w = (state_q == S_IDLE) && !rst;
  assign accept      = bus.req_valid && req_ready_w;

  // ---------------------------------------------------------------------------
  // Accept-time decode (from the live request inputs)
  // ---------------------------------------------------------------------------
  logic [2:0]        req_off;
  logic [3:0]        acc_size;
  logic [3:0]        lane_lo;
  logic [3:0]        lane_hi;
  logic [7:0]        acc_mask;
  logic              misaligned;
  logic              illegal;
  logic              acc_err;
  logic [DATA_W-1:0] acc_wdata;

  assign req_off  = bus.ram_addr[2:0];
  assign acc_size = 4'd1 << bus.req_funct3[1:0];
  assign lane_lo  = {1'b0, req_off};
  assign lane_hi  = lane_lo + acc_size;

  always_comb begin
    misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_off[0];
      2'd2:    misaligned = |req_off[1:0];
      default: misaligned = |req_off;
    endcase
  end

  // Stores only exist for funct3 000..011; loads reject only 111.
  assign illegal = bus.req_wen ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
  assign acc_err = misaligned || illegal;

  // A lane is enabled when it falls inside [offset, offset+size). For an
  // aligned access this never spills past lane 7, so it equals the
  // size-mask shifted left by the offset. Loads never enable a lane.
  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign acc_mask[gi] = bus.req_wen && (4'(gi) >= lane_lo) && (4'(gi) < lane_hi);
  end

  assign acc_wdata = bus.req_wen ? (bus.req_wdata << {req_off, 3'b000}) : '0;

  // ---------------------------------------------------------------------------
  // Load path: shift the addressed bytes down to bit 0, then extend.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ld_shifted;
  logic [DATA_W-1:0] ld_value;

  assign ld_shifted = bus.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_value = '0;
    case (funct3_q)
      3'b000:  ld_value = {{(DATA_W-8){ld_shifted[7]}},   ld_shifted[7:0]};
      3'b001:  ld_value = {{(DATA_W-16){ld_shifted[15]}}, ld_shifted[15:0]};
      3'b010:  ld_value = {{(DATA_W-32){ld_shifted[31]}}, ld_shifted[31:0]};
      3'b011:  ld_value = ld_shifted;
      3'b100:  ld_value = {{(DATA_W-8){1'b0}},  ld_shifted[7:0]};
      3'b101:  ld_value = {{(DATA_W-16){1'b0}}, ld_shifted[15:0]};
      3'b110:  ld_value = {{(DATA_W-32){1'b0}}, ld_shifted[31:0]};
      default: ld_value = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    off_d           = off_q;
    funct3_d        = funct3_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    mem_wen_d       = mem_wen_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wmask_d     = mem_wmask_q;
    resp_valid_d    = 1'b0;
    resp_data_d     = '0;
    resp_err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          off_d    = req_off;
          funct3_d = bus.req_funct3;
          if (acc_err) begin
            // Answer straight away; memory never sees this access.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = S_RESP;
          end else begin
            mem_req_valid_d = 1'b1;
            mem_addr_d      = {bus.ram_addr[ADDR_W-1:3], 3'b000};
            mem_wen_d       = bus.req_wen;
            mem_wdata_d     = acc_wdata;
            mem_wmask_d     = acc_mask;
            state_d         = S_REQ;
          end
        end
      end

      S_REQ: begin
        // mem_* fields are simply held until the memory takes them.
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          resp_valid_d = 1'b1;
          resp_data_d  = mem_wen_q ? '0 : ld_value;
          state_d      = S_RESP;
        end
      end

      default: begin
        // S_RESP: the response pulse is on the outputs this cycle.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      off_q           <= '0;
      funct3_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      off_q           <= off_d;
      funct3_q        <= funct3_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      mem_wen_q       <= mem_wen_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wmask_q     <= mem_wmask_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_err_q      <= resp_err_d;
    end
  end

  assign bus.req_ready     = req_ready_w;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wen       = mem_wen_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_wmask     = mem_wmask_q;

endmodule

// File: tb/tb_lsu_unit.sv
// Testbench for lsu_unit. A byte-addressed reference memory predicts every
// load result, error flag and response cycle; expectations are queued at
// accept time and a separate monitor pops them when resp_valid appears.
// A memory responder serves the doubleword port from its own storage,
// using the unit's masks/lanes, and checks each request against the queue.
module tb_lsu_unit;

  localparam logic [63:0] BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_unit_if #(.ADDR_W(64), .DATA_W(64)) bus ();

  lsu_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [7:0]  mask;
    logic [63:0] wdata;
    int          rs;
    int          ws;
  } mreq_t;

  resp_t sb[$];
  mreq_t mq[$];

  logic [7:0]  ref_mem [0:511];  // reference view: plain bytes
  logic [63:0] dw_mem  [0:63];   // memory-port view: doublewords

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic preload(input logic [63:0] addr, input logic [63:0] dw);
    int idx;
    idx = int'((addr - BASE) >> 3);
    dw_mem[idx] = dw;
    for (int j = 0; j < 8; j++) ref_mem[idx*8 + j] = dw[8*j +: 8];
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Present one access, wait for it to be accepted, and queue its expectations.
  task automatic issue(input logic wen, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, input int rs, input int ws,
                       input bit want_resp, output int acc_cyc);
    int          size, off, ofs;
    bit          err, got;
    logic [63:0] v;
    resp_t       r;
    mreq_t       m;
    size = 1 << f3[1:0];
    off  = int'(addr % 8);
    ofs  = int'(addr - BASE);
    err  = (wen ? (f3 >= 3'd4) : (f3 == 3'd7)) || ((addr % 64'(size)) != 0);
    v    = '0;
    if (!wen && !err) begin
      for (int k = 0; k < size; k++) v = v | (64'(ref_mem[ofs + k]) << (8*k));
      if (f3 < 3'd3 && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
    end
    r.data  = v;
    r.err   = err;
    m.addr  = addr - 64'(off);
    m.wen   = wen;
    m.mask  = wen ? 8'(((1 << size) - 1) << off) : 8'h00;
    m.wdata = wen ? (wdata << (8*off)) : 64'd0;
    m.rs    = rs;
    m.ws    = ws;

    @(posedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_wen    = wen;
    bus.req_funct3 = f3;
    bus.ram_addr   = addr;
    bus.req_wdata  = wdata;
    got     = 1'b0;
    acc_cyc = -1;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      fail_now("accept_timeout");
      return;
    end
    acc_cyc = cyc;
    r.due   = cyc + (err ? 1 : 3 + rs + ws);
    if (!err) mq.push_back(m);
    if (want_resp) sb.push_back(r);
    if (wen && !err)
      for (int k = 0; k < size; k++) ref_mem[ofs + k] = wdata[8*k +: 8];
  endtask

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin : mon_blk
        resp_t r;
        if (sb.size() == 0) begin
          fail_now("unexpected_resp");
        end else begin
          r = sb.pop_front();
          check("resp_data", bus.resp_data, r.data);
          check("resp_err", 64'(bus.resp_err), 64'(r.err));
          check("resp_cycle", 64'(cyc), 64'(r.due));
          $display("resp cycle=%0d data=0x%h err=%0d", cyc, bus.resp_data, bus.resp_err);
        end
      end
    end
  end

  // Memory responder.
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid === 1'b1) begin : srv_blk
        mreq_t       m;
        bit          known;
        int          idx;
        logic        act_wen;
        logic [7:0]  act_mask;
        logic [63:0] act_wdata;
        known = (mq.size() != 0);
        if (known) m = mq.pop_front();
        else begin
          fail_now("unexpected_mem_req");
          m = '{addr: BASE, wen: 1'b0, mask: 8'h00, wdata: 64'd0, rs: 0, ws: 0};
        end
        for (int i = 0; i <= m.rs; i++) begin
          if (i > 0) @(negedge clk);
          if (known) begin
            check("mem_req_valid_held", 64'(bus.mem_req_valid), 64'd1);
            check("mem_addr", bus.mem_addr, m.addr);
            check("mem_wen", 64'(bus.mem_wen), 64'(m.wen));
            check("mem_wmask", 64'(bus.mem_wmask), 64'(m.mask));
            if (m.wen) check("mem_wdata", bus.mem_wdata, m.wdata);
          end
        end
        act_wen   = bus.mem_wen;
        act_mask  = bus.mem_wmask;
        act_wdata = bus.mem_wdata;
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        check("mem_req_dropped", 64'(bus.mem_req_valid), 64'd0);
        repeat (m.ws) @(negedge clk);
        idx = int'(((m.addr - BASE) >> 3) & 64'd63);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata     = act_wen ? {$urandom, $urandom} : dw_mem[idx];
        if (act_wen)
          for (int j = 0; j < 8; j++)
            if (act_mask[j]) dw_mem[idx][8*j +: 8] = act_wdata[8*j +: 8];
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rdata     = {$urandom, $urandom};
      end
    end
  end

  // Stimulus.
  initial begin
    int a, b;
    bus.req_valid  = 1'b0;
    bus.req_wen    = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.ram_addr   = '0;
    bus.req_wdata  = '0;
    for (int i = 0; i < 64; i++) preload(BASE + 64'(8*i), {$urandom, $urandom});

    // Reset values, while reset is held and in the first cycle after it.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_err", 64'(bus.resp_err), 64'd0);
    check("rst_resp_data", bus.resp_data, 64'd0);
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    check("rst_mem_wen", 64'(bus.mem_wen), 64'd0);
    check("rst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_mem_wdata", bus.mem_wdata, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("post_rst_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);

    // LW, zero-wait memory.
    preload(BASE, 64'h8765_4321_0000_0000);
    issue(1'b0, 3'b010, BASE + 64'd4, 64'd0, 0, 0, 1'b1, a);
    idle(2);
    // LBU with a two-cycle request stall.
    preload(BASE, 64'hAB00_0000_0000_0000);
    issue(1'b0, 3'b100, BASE + 64'd7, 64'd0, 2, 0, 1'b1, a);
    idle(2);
    // SH into the top two lanes.
    issue(1'b1, 3'b001, BASE + 64'd6, 64'h1234, 0, 0, 1'b1, a);
    idle(2);
    // Misaligned LD, then illegal load funct3.
    issue(1'b0, 3'b011, BASE + 64'd4, 64'd0, 0, 0, 1'b1, a);
    issue(1'b0, 3'b111, BASE + 64'd8, 64'd0, 0, 0, 1'b1, a);
    idle(2);

    // Reset while waiting for the memory response; the late response is ignored.
    issue(1'b0, 3'b011, BASE + 64'd16, 64'd0, 0, 3, 1'b0, a);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wait_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_wait_mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    idle(8);

    // Back-to-back SD then LD with req_valid held high.
    issue(1'b1, 3'b011, BASE + 64'd8, 64'hCAFE_F00D_1234_5678, 2, 0, 1'b1, a);
    issue(1'b0, 3'b011, BASE + 64'd8, 64'd0, 0, 0, 1'b1, b);
    check("b2b_interval", 64'(b - a), 64'd6);
    idle(2);

    // Random traffic.
    for (int n = 0; n < 150; n++) begin : rnd_blk
      logic        wen;
      logic [2:0]  f3;
      logic [63:0] addr;
      int          sz;
      wen = 1'($urandom_range(0, 1));
      if (wen) f3 = ($urandom_range(0, 9) == 0) ? 3'(4 + $urandom_range(0, 3))
                                                : 3'($urandom_range(0, 3));
      else     f3 = 3'($urandom_range(0, 7));
      addr = BASE + 64'($urandom_range(0, 511));
      sz   = 1 << f3[1:0];
      if ($urandom_range(0, 3) != 0) addr = addr & ~64'(sz - 1);
      issue(wen, f3, addr, {$urandom, $urandom},
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, a);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(0, 2)));
    end
    idle(1);

    for (int t = 0; t < 200 && (sb.size() != 0 || mq.size() != 0); t++) @(negedge clk);
    check("resp_queue_drained", 64'(sb.size()), 64'd0);
    check("mem_queue_drained", 64'(mq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
